// File: rtl/platform_field.sv
// rtl/platform_field.sv - playfield platform store with LFSR respawn, frame scroll and per-pixel hit test
// Optional macro PLAT_MOTION_EN adds horizontal drift on odd-index platforms.
module platform_field #(
    parameter int          NUM_PLAT    = 16,
    parameter int          PLAT_HALF_W = 16,
    parameter int          PLAT_HALF_H = 4,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] scroll_amt,
    input  logic       scroll_valid,
    output logic       scroll_ready,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       plat_on,
    output logic [4:0] plat_idx,
    output logic       busy
);
    localparam int IW    = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam int RANGE = SCREEN_W - 2 * PLAT_HALF_W;
    localparam logic [IW-1:0]     LAST = IW'(NUM_PLAT - 1);
    localparam logic signed [11:0] HW  = 12'(PLAT_HALF_W);
    localparam logic signed [11:0] HH  = 12'(PLAT_HALF_H);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPDATE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [9:0]    px [NUM_PLAT];
    logic [9:0]    py [NUM_PLAT];
    logic [9:0]    pending;
    logic [IW-1:0] idx;
    logic          frame_q;
    logic          frame_rise;
    logic [9:0]    rnd_r;
    logic [9:0]    rand_x;
    logic [10:0]   t_sum;
    logic [9:0]    clamp_amt;
    logic          hit_any;
    logic [4:0]    hit_idx;
    logic signed [11:0] dx, dy, xs, ys;

`ifdef PLAT_MOTION_EN
    localparam int DW = (IW > 1) ? IW - 1 : 1;
    localparam logic [9:0] XMIN = 10'(PLAT_HALF_W);
    localparam logic [9:0] XMAX = 10'(SCREEN_W - 1 - PLAT_HALF_W);
    logic          dir [(NUM_PLAT + 1) / 2];
    logic [DW-1:0] didx;
    logic          mv_dir;
    logic [9:0]    mv_x;

    // Direction flips at a wall and the same cycle's step already goes the new way.
    always_comb begin
        didx   = DW'(idx >> 1);
        mv_dir = dir[didx];
        if ((!dir[didx] && px[idx] == XMAX) || (dir[didx] && px[idx] == XMIN))
            mv_dir = ~dir[didx];
        mv_x = mv_dir ? px[idx] - 10'd1 : px[idx] + 10'd1;
    end
`endif

    always_comb begin
        lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        frame_rise = frame_clk && !frame_q;
        rnd_r      = lfsr[9:0];
        if (rnd_r >= 10'(RANGE))
            rnd_r = rnd_r - 10'(RANGE);
        rand_x    = 10'(PLAT_HALF_W) + rnd_r;
        t_sum     = {1'b0, py[idx]} + {1'b0, pending};
        clamp_amt = (scroll_amt > 10'(SCREEN_H - 1)) ? 10'(SCREEN_H - 1) : scroll_amt;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= S_INIT;
            idx          <= '0;
            lfsr         <= LFSR_SEED;
            pending      <= '0;
            frame_q      <= 1'b0;
            busy         <= 1'b1;
            scroll_ready <= 1'b0;
            for (int k = 0; k < NUM_PLAT; k++) begin
                px[k] <= '0;
                py[k] <= 10'(k * (SCREEN_H / NUM_PLAT));
            end
`ifdef PLAT_MOTION_EN
            for (int k = 0; k < (NUM_PLAT + 1) / 2; k++)
                dir[k] <= 1'b0;
`endif
        end else begin
            lfsr    <= lfsr_next;
            frame_q <= frame_clk;
            case (state)
                S_INIT: begin
                    px[idx] <= rand_x;
                    if (idx == LAST) begin
                        state        <= S_IDLE;
                        idx          <= '0;
                        busy         <= 1'b0;
                        scroll_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (scroll_valid && scroll_ready)
                        pending <= clamp_amt;
                    if (frame_rise) begin
                        state        <= S_UPDATE;
                        idx          <= '0;
                        busy         <= 1'b1;
                        scroll_ready <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    if (t_sum >= 11'(SCREEN_H)) begin
                        py[idx] <= 10'(t_sum - 11'(SCREEN_H));
                        px[idx] <= rand_x;
`ifdef PLAT_MOTION_EN
                        if (idx[0])
                            dir[didx] <= 1'b0;
`endif
                    end else begin
                        py[idx] <= t_sum[9:0];
`ifdef PLAT_MOTION_EN
                        if (idx[0]) begin
                            dir[didx] <= mv_dir;
                            px[idx]   <= mv_x;
                        end
`endif
                    end
                    if (idx == LAST) begin
                        pending      <= '0;
                        state        <= S_IDLE;
                        idx          <= '0;
                        busy         <= 1'b0;
                        scroll_ready <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Scan from the top index down so the lowest hitting index is the one kept.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        dx      = $signed({2'b00, DrawX});
        dy      = $signed({2'b00, DrawY});
        xs      = '0;
        ys      = '0;
        for (int k = NUM_PLAT - 1; k >= 0; k--) begin
            xs = $signed({2'b00, px[k]});
            ys = $signed({2'b00, py[k]});
            if (dx >= xs - HW && dx <= xs + HW && dy >= ys - HH && dy <= ys + HH) begin
                hit_any = 1'b1;
                hit_idx = 5'(k);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            plat_on  <= 1'b0;
            plat_idx <= '0;
        end else begin
            plat_on  <= hit_any && (state != S_INIT);
            plat_idx <= hit_idx;
        end
    end
endmodule
